bram_pq_arbiter: RTL and testbench
==================================

Name: bram_pq_arbiter

Overview:
Shares one bram_tree max-priority queue between NUM_CLIENTS requesters. Each client issues enqueue, dequeue, replace or peek requests. The block grants clients round-robin and drives the queue's single-cycle write/read strobes. It enforces the queue's settle time between operations and returns a result and error flag to the granted client. It sits between client logic (schedulers, search engines) and the bram_tree instance.

Parameters:
NUM_CLIENTS, 4, number of requesters (>=2)
DATA_WIDTH, 16, key width; must match the bram_tree DATA_WIDTH
OP_LATENCY, 5, idle cycles the queue needs after a strobe before its outputs are valid
CW, $clog2(NUM_CLIENTS), client index width (localparam)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
i_req  in  NUM_CLIENTS  per-client request level
i_op  in  NUM_CLIENTS x 2  per-client opcode (see package)
i_data  in  NUM_CLIENTS x DATA_WIDTH  per-client key for ENQ/REP
o_gnt  out  NUM_CLIENTS  one-hot; high from ISSUE through DONE for the served client
o_done  out  NUM_CLIENTS  one-cycle completion pulse to the served client
o_rdata  out  DATA_WIDTH  result, valid with o_done
o_err  out  1  op rejected, valid with o_done
o_pq_wrt  out  1  to bram_tree i_wrt
o_pq_read  out  1  to bram_tree i_read
o_pq_data  out  DATA_WIDTH  to bram_tree i_data
i_pq_full  in  1  from bram_tree o_full
i_pq_empty  in  1  from bram_tree o_empty
i_pq_data  in  DATA_WIDTH  from bram_tree o_data (root; 0 when empty)

Behaviour:
- Reset (RST high at a CLK edge): state=IDLE, rr pointer=0, all outputs 0. RST mid-operation aborts the op. No o_done is issued for it. Strobes are low the next cycle. Any queue change already issued stands.
- Client handshake: the client raises i_req and holds i_op/i_data stable until it sees o_done. It drops i_req the cycle after o_done or issues its next request. The block ignores changes of a non-granted request.
- Arbitration in IDLE: round-robin. The search starts at index (last_served+1) mod N; after reset it starts at 0. The first requesting index wins and is latched with its op and data.
- FSM:
  IDLE -> ISSUE when any i_req is set, else stay.
  ISSUE (1 cycle) -> WAIT, or -> DONE for PEEK or a rejected op.
  WAIT -> DONE after OP_LATENCY cycles.
  DONE (1 cycle) -> IDLE.
- ISSUE actions:
  ENQ: reject if i_pq_full, else o_pq_wrt=1.
  DEQ: reject if i_pq_empty, else o_pq_read=1.
  REP: reject if empty, else o_pq_wrt=1 and o_pq_read=1.
  o_pq_data = latched key. i_pq_data is sampled into the result register in this cycle, as the pre-op root.
  Strobes are high for exactly this one cycle; no strobe on PEEK or on a rejected op.
- DONE actions: o_done[granted]=1, o_err set if rejected, rr pointer updated to the granted index.
- o_rdata by op:
  DEQ, REP: the popped pre-op root.
  ENQ: the post-settle root, sampled at the last WAIT cycle.
  PEEK: the current root.
  Rejected: 0.
- Latency per op: ENQ/DEQ/REP take 1+OP_LATENCY+1 cycles from IDLE-grant to o_done. PEEK and rejects take 2 cycles.
- A served client with i_req still high competes again only after all other requesters (fairness). A sole requester is re-granted back-to-back with one IDLE cycle between ops.

Decomposition:
- Package bram_pq_pkg:
  op_t enum {OP_ENQ=2'b00, OP_DEQ=2'b01, OP_REP=2'b10, OP_PEEK=2'b11}
  state_t enum {IDLE, ISSUE, WAIT, DONE}
- Sub-module rr_arbiter (NUM_CLIENTS): request vector and pointer in, one-hot grant and index out, purely combinational. It is reusable by other shared resources.

Test Plan:
- Reset: hold RST 2 cycles -> all outputs 0, state IDLE. A request issued during reset gets no grant.
- Single client 0: ENQ 100, ENQ 300, ENQ 200, then DEQ. Each ENQ gives o_done at cycle 7 after grant. Final DEQ returns o_rdata=300, o_err=0. A following PEEK returns 200 with o_done 2 cycles after grant.
- Round-robin: clients 0-3 all request ENQ (keys 10, 20, 30, 40) simultaneously -> grants in order 0,1,2,3. o_pq_wrt pulses exactly 4 times, each a single cycle, with at least OP_LATENCY idle cycles between pulses.
- Boundaries:
  - DEQ on an empty queue -> o_err=1, o_rdata=0, o_pq_read never asserted.
  - Fill a QUEUE_SIZE=7 tree, then ENQ -> o_err=1, no o_pq_wrt.
- REP on a queue holding {500, 50}, replacing with 5 -> o_rdata=500, o_pq_wrt and o_pq_read both high in the same cycle. A following PEEK returns 50.
- Reset mid-WAIT of a DEQ -> no o_done pulse, o_gnt clears the next cycle. After reset, client 0 is granted first when all clients request.

Source files
------------

// File: rtl/bram_pq_pkg.sv
// Shared types for the bram_tree priority-queue arbiter: opcodes, FSM states
// and the reject rule applied before a strobe is issued.
package bram_pq_pkg;

    typedef enum logic [1:0] {
        OP_ENQ  = 2'b00,
        OP_DEQ  = 2'b01,
        OP_REP  = 2'b10,
        OP_PEEK = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    // An op is rejected when the queue cannot honour it; PEEK never is.
    function automatic logic op_rejected(input op_t op, input logic full, input logic empty);
        logic rej;
        case (op)
            OP_ENQ:  rej = full;
            OP_DEQ:  rej = empty;
            OP_REP:  rej = empty;
            default: rej = 1'b0;
        endcase
        return rej;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping) wins; reusable for any shared resource.
module rr_arbiter #(
    parameter  int NUM_CLIENTS = 4,
    localparam int CW          = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [CW-1:0]          ptr,
    output logic [NUM_CLIENTS-1:0] gnt,
    output logic [CW-1:0]          idx
);
    localparam int CW1 = CW + 1;

    logic [CW:0] cand_s;
    logic        found_s;

    // Scan from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        cand_s  = '0;
        found_s = 1'b0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            cand_s = {1'b0, ptr} + CW1'(i);
            if (cand_s >= CW1'(NUM_CLIENTS)) begin
                cand_s = cand_s - CW1'(NUM_CLIENTS);
            end else begin
                cand_s = cand_s;
            end
            if (req[cand_s[CW-1:0]]) begin
                idx     = cand_s[CW-1:0];
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            gnt[idx] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/bram_pq_arbiter.sv
// Round-robin front end sharing one bram_tree max-priority queue between
// several clients; issues single-cycle strobes and waits out the settle time.
module bram_pq_arbiter
    import bram_pq_pkg::*;
#(
    parameter  int NUM_CLIENTS = 4,
    parameter  int DATA_WIDTH  = 16,
    parameter  int OP_LATENCY  = 5,
    localparam int CW          = $clog2(NUM_CLIENTS)
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [NUM_CLIENTS-1:0]                i_req,
    input  logic [NUM_CLIENTS-1:0][1:0]           i_op,
    input  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] i_data,
    output logic [NUM_CLIENTS-1:0]                o_gnt,
    output logic [NUM_CLIENTS-1:0]                o_done,
    output logic [DATA_WIDTH-1:0]                 o_rdata,
    output logic                                  o_err,
    output logic                                  o_pq_wrt,
    output logic                                  o_pq_read,
    output logic [DATA_WIDTH-1:0]                 o_pq_data,
    input  logic                                  i_pq_full,
    input  logic                                  i_pq_empty,
    input  logic [DATA_WIDTH-1:0]                 i_pq_data
);
    localparam int LW = $clog2(OP_LATENCY + 1);

    state_t                 state_r;
    logic [CW-1:0]          ptr_r;
    logic [CW-1:0]          idx_r;
    op_t                    op_r;
    logic                   rej_r;
    logic [DATA_WIDTH-1:0]  res_r;
    logic [LW-1:0]          cnt_r;

    logic [NUM_CLIENTS-1:0] arb_gnt_s;
    logic [CW-1:0]          arb_idx_s;
    op_t                    win_op_s;
    logic                   win_rej_s;

    rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS)) u_rr (
        .req (i_req),
        .ptr (ptr_r),
        .gnt (arb_gnt_s),
        .idx (arb_idx_s)
    );

    // Queue flags are settled throughout IDLE, so the reject decision taken on
    // the IDLE->ISSUE edge matches what the queue reports during ISSUE.
    assign win_op_s  = op_t'(i_op[arb_idx_s]);
    assign win_rej_s = op_rejected(win_op_s, i_pq_full, i_pq_empty);

    // Operation sequencer: grant, strobe, settle, report.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            idx_r     <= '0;
            op_r      <= OP_ENQ;
            rej_r     <= 1'b0;
            res_r     <= '0;
            cnt_r     <= '0;
            o_gnt     <= '0;
            o_done    <= '0;
            o_rdata   <= '0;
            o_err     <= 1'b0;
            o_pq_wrt  <= 1'b0;
            o_pq_read <= 1'b0;
            o_pq_data <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|i_req) begin
                        idx_r     <= arb_idx_s;
                        op_r      <= win_op_s;
                        rej_r     <= win_rej_s;
                        cnt_r     <= '0;
                        o_gnt     <= arb_gnt_s;
                        o_pq_data <= i_data[arb_idx_s];
                        o_pq_wrt  <= ~win_rej_s & ((win_op_s == OP_ENQ) | (win_op_s == OP_REP));
                        o_pq_read <= ~win_rej_s & ((win_op_s == OP_DEQ) | (win_op_s == OP_REP));
                        state_r   <= ISSUE;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                ISSUE: begin
                    o_pq_wrt  <= 1'b0;
                    o_pq_read <= 1'b0;
                    res_r     <= i_pq_data;
                    if (rej_r || (op_r == OP_PEEK)) begin
                        o_done  <= o_gnt;
                        o_err   <= rej_r;
                        o_rdata <= rej_r ? '0 : i_pq_data;
                        state_r <= DONE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r == LW'(OP_LATENCY - 1)) begin
                        o_done  <= o_gnt;
                        o_err   <= 1'b0;
                        // ENQ reports the settled root; DEQ/REP the popped one.
                        o_rdata <= (op_r == OP_ENQ) ? i_pq_data : res_r;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + LW'(1);
                    end
                end
                DONE: begin
                    o_done  <= '0;
                    o_err   <= 1'b0;
                    o_rdata <= '0;
                    o_gnt   <= '0;
                    ptr_r   <= (idx_r == CW'(NUM_CLIENTS - 1)) ? '0 : idx_r + CW'(1);
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_pq_arbiter.sv
// Directed bench for bram_pq_arbiter with a small behavioural max-queue
// (capacity 7, outputs delayed a few cycles) standing in for bram_tree.
module tb_bram_pq_arbiter;
    import bram_pq_pkg::*;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [3:0]       i_req = '0;
    logic [3:0][1:0]  i_op = '0;
    logic [3:0][15:0] i_data = '0;
    logic [3:0]       o_gnt, o_done;
    logic [15:0]      o_rdata, o_pq_data, i_pq_data;
    logic             o_err, o_pq_wrt, o_pq_read, i_pq_full, i_pq_empty;

    int n_tests = 0;
    int n_fail  = 0;
    int seq     = 0;

    bram_pq_arbiter #(.NUM_CLIENTS(4), .DATA_WIDTH(16), .OP_LATENCY(5)) dut (
        .CLK(CLK), .RST(RST), .i_req(i_req), .i_op(i_op), .i_data(i_data),
        .o_gnt(o_gnt), .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err),
        .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read), .o_pq_data(o_pq_data),
        .i_pq_full(i_pq_full), .i_pq_empty(i_pq_empty), .i_pq_data(i_pq_data)
    );

    always #5 CLK = ~CLK;

    // Behavioural queue model
    logic [15:0]      mq [0:7];
    int               mcnt = 0;
    int               maxi;
    logic [15:0]      root;
    logic [2:0][15:0] dpipe = '0;
    logic [2:0]       fpipe = '0;
    logic [2:0]       epipe = '1;

    // Strobe monitor
    int cyc = 0, last_wrt = -1, wrt_cnt = 0, rd_cnt = 0, both_cnt = 0, wide_cnt = 0, gap_bad = 0;
    logic wrt_prev = 1'b0, rd_prev = 1'b0;

    always_comb begin
        maxi = 0;
        root = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < mcnt && mq[k] >= root) begin
                root = mq[k];
                maxi = k;
            end
        end
    end

    assign i_pq_data  = dpipe[2];
    assign i_pq_full  = fpipe[2];
    assign i_pq_empty = epipe[2];

    always @(posedge CLK) begin
        dpipe <= {dpipe[1:0], root};
        fpipe <= {fpipe[1:0], (mcnt == 7)};
        epipe <= {epipe[1:0], (mcnt == 0)};
        if (o_pq_wrt && !o_pq_read) begin
            mq[mcnt] <= o_pq_data;
            mcnt     <= mcnt + 1;
        end else if (o_pq_read && !o_pq_wrt) begin
            mq[maxi] <= mq[mcnt-1];
            mcnt     <= mcnt - 1;
        end else if (o_pq_read && o_pq_wrt) begin
            mq[maxi] <= o_pq_data;
        end
        cyc      <= cyc + 1;
        wrt_prev <= o_pq_wrt;
        rd_prev  <= o_pq_read;
        if (o_pq_wrt) begin
            wrt_cnt  <= wrt_cnt + 1;
            last_wrt <= cyc;
            if (last_wrt >= 0 && (cyc - last_wrt - 1) < 5) gap_bad <= gap_bad + 1;
        end
        if (o_pq_read) rd_cnt <= rd_cnt + 1;
        if (o_pq_read && o_pq_wrt) both_cnt <= both_cnt + 1;
        if ((o_pq_wrt && wrt_prev) || (o_pq_read && rd_prev)) wide_cnt <= wide_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Raise a request, hold until o_done, then drop it; lat counts cycles from request.
    task automatic run_op(input int c, input logic [1:0] op, input logic [15:0] d,
                          output logic [15:0] rd, output logic er, output int lat, output int ord);
        @(negedge CLK);
        i_op[c]   = op;
        i_data[c] = d;
        i_req[c]  = 1'b1;
        lat = 0; rd = '0; er = 1'b0; ord = -1;
        while (lat < 100) begin
            @(negedge CLK);
            lat++;
            if (o_done[c]) begin
                rd  = o_rdata;
                er  = o_err;
                ord = seq;
                seq++;
                break;
            end
        end
        i_req[c] = 1'b0;
    endtask

    task automatic op_chk(input string tag, input int c, input logic [1:0] op, input logic [15:0] d,
                          input logic [15:0] exp_rd, input logic exp_err, input int exp_lat);
        logic [15:0] rd;
        logic        er;
        int          lat, ord;
        run_op(c, op, d, rd, er, lat, ord);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, er, exp_err);
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    logic [15:0] rd_a [4];
    logic        er_a [4];
    int          lat_a [4];
    int          ord_a [4];
    int          snap;
    logic        done_seen;
    logic [15:0] drain_exp [7];

    initial begin
        drain_exp = '{16'd200, 16'd100, 16'd40, 16'd30, 16'd20, 16'd10, 16'd7};

        // Reset with a request pending
        i_req[0] = 1'b1;
        i_op[0]  = OP_PEEK;
        repeat (2) @(negedge CLK);
        check("rst_gnt", o_gnt, 4'd0);
        check("rst_done", o_done, 4'd0);
        check("rst_strobes", {o_pq_wrt, o_pq_read}, 2'd0);
        check("rst_rdata", {o_err, o_rdata}, 17'd0);
        i_req = '0;
        RST   = 1'b0;
        @(negedge CLK);
        check("post_rst_gnt", o_gnt, 4'd0);

        snap = rd_cnt;
        op_chk("deq_empty", 0, OP_DEQ, 16'd0, 16'd0, 1'b1, 2);
        check("deq_empty_noread", rd_cnt - snap, 0);

        op_chk("enq100", 0, OP_ENQ, 16'd100, 16'd100, 1'b0, 7);
        op_chk("enq300", 0, OP_ENQ, 16'd300, 16'd300, 1'b0, 7);
        op_chk("enq200", 0, OP_ENQ, 16'd200, 16'd300, 1'b0, 7);
        op_chk("deq300", 0, OP_DEQ, 16'd0, 16'd300, 1'b0, 7);
        op_chk("peek200", 0, OP_PEEK, 16'd0, 16'd200, 1'b0, 2);

        // Round-robin from a fresh pointer
        pulse_reset();
        snap = wrt_cnt;
        fork
            run_op(0, OP_ENQ, 16'd10, rd_a[0], er_a[0], lat_a[0], ord_a[0]);
            run_op(1, OP_ENQ, 16'd20, rd_a[1], er_a[1], lat_a[1], ord_a[1]);
            run_op(2, OP_ENQ, 16'd30, rd_a[2], er_a[2], lat_a[2], ord_a[2]);
            run_op(3, OP_ENQ, 16'd40, rd_a[3], er_a[3], lat_a[3], ord_a[3]);
        join
        for (int c = 0; c < 4; c++) check($sformatf("rr_order%0d", c), ord_a[c] - ord_a[0], c);
        check("rr_wrt_pulses", wrt_cnt - snap, 4);
        check("rr_wide", wide_cnt, 0);
        check("rr_gap", gap_bad, 0);

        // Fill to 7 then overflow
        op_chk("enq7", 2, OP_ENQ, 16'd7, 16'd200, 1'b0, 7);
        snap = wrt_cnt;
        op_chk("enq_full", 2, OP_ENQ, 16'd999, 16'd0, 1'b1, 2);
        check("enq_full_nowrt", wrt_cnt - snap, 0);
        for (int k = 0; k < 7; k++) begin
            op_chk($sformatf("drain%0d", k), 3, OP_DEQ, 16'd0, drain_exp[k], 1'b0, 7);
        end

        // Replace
        op_chk("enq500", 1, OP_ENQ, 16'd500, 16'd500, 1'b0, 7);
        op_chk("enq50", 1, OP_ENQ, 16'd50, 16'd500, 1'b0, 7);
        snap = both_cnt;
        op_chk("rep5", 1, OP_REP, 16'd5, 16'd500, 1'b0, 7);
        check("rep_both", both_cnt - snap, 1);
        op_chk("peek50", 1, OP_PEEK, 16'd0, 16'd50, 1'b0, 2);

        // Reset in the middle of a DEQ wait
        @(negedge CLK);
        i_op[1]  = OP_DEQ;
        i_req[1] = 1'b1;
        done_seen = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            if (o_done != 4'd0) done_seen = 1'b1;
        end
        RST = 1'b1;
        @(negedge CLK);
        if (o_done != 4'd0) done_seen = 1'b1;
        check("abort_gnt", o_gnt, 4'd0);
        check("abort_nodone", done_seen, 1'b0);
        i_req[1] = 1'b0;
        RST = 1'b0;
        fork
            run_op(0, OP_PEEK, 16'd0, rd_a[0], er_a[0], lat_a[0], ord_a[0]);
            run_op(1, OP_PEEK, 16'd0, rd_a[1], er_a[1], lat_a[1], ord_a[1]);
            run_op(2, OP_PEEK, 16'd0, rd_a[2], er_a[2], lat_a[2], ord_a[2]);
            run_op(3, OP_PEEK, 16'd0, rd_a[3], er_a[3], lat_a[3], ord_a[3]);
        join
        check("abort_first0", ord_a[1] - ord_a[0], 1);
        check("abort_peek", rd_a[0], 16'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule
